qtz_map_engine: RTL and testbench

QTZ_MAP_ENGINE -- requirements
Module: qtz_map_engine

---
 rtl/qtz_pkg.sv | 45 ++++
 rtl/qtz_map_engine_if.sv | 36 +++
 rtl/qtz_lane.sv | 104 ++++++++++
 rtl/qtz_map_engine.sv | 170 +++++++++++++++++
 tb/tb_qtz_map_engine.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/qtz_pkg.sv
// qtz_pkg: shared definitions for the quantize-and-map engine.
//   - default parameter values (sample geometry, base hypervector seed word)
//   - FSM state enum
//   - geometry helpers: chunk count, segment count, index widths, level flip length
package qtz_pkg;

   localparam int unsigned DEF_HV_DIM        = 4096;
   localparam int unsigned DEF_FEATURE_COUNT = 617;
   localparam int unsigned DEF_LANES         = 155;
   localparam int unsigned DEF_SEG_W         = 1024;
   localparam int unsigned DEF_NUM_LEVELS    = 16;
   localparam int unsigned DEF_VALUE_W       = 16;

   // Level-0 hypervector is this word replicated; HV_DIM must be a multiple of 32
   // when the default BASE_HV is used.
   localparam logic [31:0] DEF_BASE_WORD = 32'h9E37_79B9;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_IN,
      MAP,
      DONE
   } state_e;

   function automatic int unsigned num_chunks(input int unsigned feature_count,
                                              input int unsigned lanes);
      return (feature_count + lanes - 1) / lanes;
   endfunction

   function automatic int unsigned num_segs(input int unsigned hv_dim, input int unsigned seg_w);
      return hv_dim / seg_w;
   endfunction

   // Index width that never collapses to zero bits.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Number of low-order bits inverted for level l; the top level flips exactly hv_dim/2.
   function automatic int unsigned flip_len(input int unsigned l, input int unsigned hv_dim,
                                            input int unsigned num_levels);
      return (l * hv_dim) / (2 * (num_levels - 1));
   endfunction

endpackage

// File: rtl/qtz_map_engine_if.sv
// qtz_map_engine_if: feature-input and segment-output streams of the map engine.
//   in_valid/in_ready/in_values        : one beat of LANES features
//   out_valid/out_ready/out_segs       : one HV segment per lane
//   out_lane_mask, out_chunk, out_seg  : beat qualifiers and coordinates
// master = engine side, slave = producer/consumer side.
interface qtz_map_engine_if
   import qtz_pkg::*;
#(
   parameter int unsigned LANES     = DEF_LANES,
   parameter int unsigned VALUE_W   = DEF_VALUE_W,
   parameter int unsigned SEG_W     = DEF_SEG_W,
   parameter int unsigned CHUNK_W   = 2,
   parameter int unsigned SEG_IDX_W = 2
);

   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*VALUE_W-1:0] in_values;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES*SEG_W-1:0]   out_segs;
   logic [LANES-1:0]         out_lane_mask;
   logic [CHUNK_W-1:0]       out_chunk;
   logic [SEG_IDX_W-1:0]     out_seg;

   modport master (
      input  in_valid, in_values, out_ready,
      output in_ready, out_valid, out_segs, out_lane_mask, out_chunk, out_seg
   );

   modport slave (
      output in_valid, in_values, out_ready,
      input  in_ready, out_valid, out_segs, out_lane_mask, out_chunk, out_seg
   );

endinterface

// File: rtl/qtz_lane.sv
// qtz_lane: one feature lane.
//   Quantizes a feature value to a level code when lane_load is high, then on each
//   beat_load produces the requested SEG_W-bit segment of that level's hypervector.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   lane_load, lane_live   : capture level code; lane_live=0 marks a padding lane
//   value, offset, shift   : feature value and sample configuration
//   beat_load, beat_seg    : register the segment with index beat_seg
//   mask, seg              : registered lane-valid flag and segment data
module qtz_lane
   import qtz_pkg::*;
#(
   parameter int unsigned HV_DIM     = DEF_HV_DIM,
   parameter int unsigned SEG_W      = DEF_SEG_W,
   parameter int unsigned NUM_LEVELS = DEF_NUM_LEVELS,
   parameter int unsigned VALUE_W    = DEF_VALUE_W,
   parameter int unsigned SEG_IDX_W  = 2,
   parameter logic [HV_DIM-1:0] BASE_HV = {(HV_DIM / 32){DEF_BASE_WORD}}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 lane_load,
   input  logic                 lane_live,
   input  logic [VALUE_W-1:0]   value,
   input  logic [VALUE_W-1:0]   offset,
   input  logic [3:0]           shift,
   input  logic                 beat_load,
   input  logic [SEG_IDX_W-1:0] beat_seg,
   output logic                 mask,
   output logic [SEG_W-1:0]     seg
);

   localparam int unsigned LVL_W = $clog2(NUM_LEVELS);
   localparam logic [VALUE_W:0] MAX_LVL = (VALUE_W + 1)'(NUM_LEVELS - 1);

   logic [VALUE_W:0]   diff;
   logic [VALUE_W:0]   scaled;
   logic [LVL_W-1:0]   level_new;
   logic [LVL_W-1:0]   level_q;
   logic               live_q;
   logic               mask_q;
   logic [SEG_W-1:0]   seg_q;
   int unsigned        flip;
   int unsigned        base;
   int unsigned        run;
   logic [SEG_W-1:0]   therm;
   logic [SEG_W-1:0]   seg_new;

   // One extra bit keeps value - offset exact for any pair of VALUE_W-bit operands.
   always_comb begin
      diff   = {value[VALUE_W-1], value} - {offset[VALUE_W-1], offset};
      scaled = diff >> shift;
      if (diff[VALUE_W]) begin
         level_new = '0;
      end else if (scaled >= MAX_LVL) begin
         level_new = LVL_W'(NUM_LEVELS - 1);
      end else begin
         level_new = scaled[LVL_W-1:0];
      end
   end

   // Flip lengths are constants per level, so this loop folds into a small table.
   always_comb begin
      flip = 0;
      for (int l = 0; l < NUM_LEVELS; l++) begin
         if (level_q == LVL_W'(l)) begin
            flip = flip_len(l, HV_DIM, NUM_LEVELS);
         end
      end
      base = 32'(beat_seg) * SEG_W;
      // run = number of flipped bits falling inside this segment
      if (flip <= base) begin
         run = 0;
      end else if (flip - base >= SEG_W) begin
         run = SEG_W;
      end else begin
         run = flip - base;
      end
      therm   = ~({SEG_W{1'b1}} << run);
      seg_new = live_q ? (BASE_HV[base +: SEG_W] ^ therm) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= '0;
         live_q  <= 1'b0;
         mask_q  <= 1'b0;
         seg_q   <= '0;
      end else begin
         if (lane_load) begin
            level_q <= level_new;
            live_q  <= lane_live;
         end
         if (beat_load) begin
            mask_q <= live_q;
            seg_q  <= seg_new;
         end
      end
   end

   assign mask = mask_q;
   assign seg  = seg_q;

endmodule

// File: rtl/qtz_map_engine.sv
// qtz_map_engine: quantizes a sample of FEATURE_COUNT features, LANES per chunk,
// and streams each lane's level hypervector out as NUM_SEGS segment beats per chunk.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   start                  : begin a sample (ignored while busy)
//   cfg_offset, cfg_shift  : quantizer config, captured on the accepted start
//   busy, done             : engine active; one-cycle end-of-sample pulse
//   bus                    : feature input and segment output streams (master side)
module qtz_map_engine
   import qtz_pkg::*;
#(
   parameter int unsigned HV_DIM        = DEF_HV_DIM,
   parameter int unsigned FEATURE_COUNT = DEF_FEATURE_COUNT,
   parameter int unsigned LANES         = DEF_LANES,
   parameter int unsigned SEG_W         = DEF_SEG_W,
   parameter int unsigned NUM_LEVELS    = DEF_NUM_LEVELS,
   parameter int unsigned VALUE_W       = DEF_VALUE_W,
   parameter logic [HV_DIM-1:0] BASE_HV = {(HV_DIM / 32){DEF_BASE_WORD}}
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [VALUE_W-1:0] cfg_offset,
   input  logic [3:0]         cfg_shift,
   output logic               busy,
   output logic               done,
   qtz_map_engine_if.master   bus
);

   localparam int unsigned NUM_CHUNKS = num_chunks(FEATURE_COUNT, LANES);
   localparam int unsigned NUM_SEGS   = num_segs(HV_DIM, SEG_W);
   localparam int unsigned CHUNK_W    = idx_width(NUM_CHUNKS);
   localparam int unsigned SEG_IDX_W  = idx_width(NUM_SEGS);
   localparam logic [CHUNK_W-1:0]   LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);
   localparam logic [SEG_IDX_W-1:0] LAST_SEG   = SEG_IDX_W'(NUM_SEGS - 1);

   state_e                 state_q, state_d;
   logic [CHUNK_W-1:0]     chunk_q, chunk_d;
   logic [VALUE_W-1:0]     offset_q;
   logic [3:0]             shift_q;
   logic                   out_valid_q;
   logic [SEG_IDX_W-1:0]   out_seg_q;
   logic [CHUNK_W-1:0]     out_chunk_q;

   logic                   cfg_load;
   logic                   lane_load;
   logic                   beat_load;
   logic [SEG_IDX_W-1:0]   beat_seg;

   logic [LANES-1:0]       lane_live;
   logic [LANES-1:0]       lane_mask;
   logic [SEG_W-1:0]       lane_seg [LANES];

   always_comb begin
      state_d   = state_q;
      chunk_d   = chunk_q;
      cfg_load  = 1'b0;
      lane_load = 1'b0;
      beat_load = 1'b0;
      beat_seg  = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = WAIT_IN;
               cfg_load = 1'b1;
               chunk_d  = '0;
            end
         end
         WAIT_IN: begin
            if (bus.in_valid) begin
               lane_load = 1'b1;
               state_d   = MAP;
            end
         end
         MAP: begin
            // No beat on the bus yet means this is the first cycle in MAP: load seg 0.
            if (!out_valid_q) begin
               beat_load = 1'b1;
               beat_seg  = '0;
            end else if (bus.out_ready) begin
               if (out_seg_q == LAST_SEG) begin
                  if (chunk_q == LAST_CHUNK) begin
                     state_d = DONE;
                  end else begin
                     chunk_d = chunk_q + CHUNK_W'(1);
                     state_d = WAIT_IN;
                  end
               end else begin
                  beat_load = 1'b1;
                  beat_seg  = out_seg_q + SEG_IDX_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         chunk_q     <= '0;
         offset_q    <= '0;
         shift_q     <= '0;
         out_valid_q <= 1'b0;
         out_seg_q   <= '0;
         out_chunk_q <= '0;
      end else begin
         state_q <= state_d;
         chunk_q <= chunk_d;
         if (cfg_load) begin
            offset_q <= cfg_offset;
            shift_q  <= cfg_shift;
         end
         if (beat_load) begin
            out_valid_q <= 1'b1;
            out_seg_q   <= beat_seg;
            out_chunk_q <= chunk_q;
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      // Lanes past the end of the sample in the final chunk are padding.
      assign lane_live[k] = (32'(chunk_q) * LANES + 32'(k)) < FEATURE_COUNT;

      qtz_lane #(
         .HV_DIM     (HV_DIM),
         .SEG_W      (SEG_W),
         .NUM_LEVELS (NUM_LEVELS),
         .VALUE_W    (VALUE_W),
         .SEG_IDX_W  (SEG_IDX_W),
         .BASE_HV    (BASE_HV)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .lane_load (lane_load),
         .lane_live (lane_live[k]),
         .value     (bus.in_values[k*VALUE_W +: VALUE_W]),
         .offset    (offset_q),
         .shift     (shift_q),
         .beat_load (beat_load),
         .beat_seg  (beat_seg),
         .mask      (lane_mask[k]),
         .seg       (lane_seg[k])
      );
   end

   always_comb begin
      bus.out_segs = '0;
      for (int k = 0; k < LANES; k++) begin
         bus.out_segs[k*SEG_W +: SEG_W] = lane_seg[k];
      end
   end

   assign bus.out_lane_mask = lane_mask;
   assign bus.in_ready      = (state_q == WAIT_IN);
   assign bus.out_valid     = out_valid_q;
   assign bus.out_chunk     = out_chunk_q;
   assign bus.out_seg       = out_seg_q;
   assign busy              = (state_q != IDLE);
   assign done              = (state_q == DONE);

endmodule

// File: tb/tb_qtz_map_engine.sv
// tb_qtz_map_engine: directed bench for qtz_map_engine at default parameters.
// Beats are checked against a per-bit thermometer model of the level hypervectors.
module tb_qtz_map_engine;
   import qtz_pkg::*;

   localparam int unsigned LANES     = 155;
   localparam int unsigned VW        = 16;
   localparam int unsigned SEG_W     = 1024;
   localparam int unsigned CHUNK_W   = 2;
   localparam int unsigned SEG_IDX_W = 2;
   localparam int NCH  = 4;
   localparam int NSEG = 4;
   localparam int FC   = 617;
   localparam logic [4095:0] TB_BASE = {128{32'h9E37_79B9}};

   logic          clk;
   logic          rst;
   logic          start;
   logic [VW-1:0] cfg_offset;
   logic [3:0]    cfg_shift;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;

   qtz_map_engine_if #(
      .LANES     (LANES),
      .VALUE_W   (VW),
      .SEG_W     (SEG_W),
      .CHUNK_W   (CHUNK_W),
      .SEG_IDX_W (SEG_IDX_W)
   ) bus ();

   qtz_map_engine dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cfg_offset (cfg_offset),
      .cfg_shift  (cfg_shift),
      .busy       (busy),
      .done       (done),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Count of bits in lane k's segment that differ from the thermometer model.
   function automatic int seg_diff(input int k, input int lvl, input bit live, input int s);
      int n;
      int flip;
      int i;
      logic e;
      n    = 0;
      flip = lvl * 4096 / 30;
      for (int j = 0; j < 1024; j++) begin
         i = s * 1024 + j;
         e = live ? (TB_BASE[i] ^ (i < flip)) : 1'b0;
         if (bus.out_segs[k*1024 + j] !== e) n++;
      end
      return n;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_mask"}, 32'($countones(bus.out_lane_mask)), 0);
      check({tag, "_chunk"}, 32'(bus.out_chunk), 0);
      check({tag, "_seg"}, 32'(bus.out_seg), 0);
      check({tag, "_segs"}, 32'($countones(bus.out_segs)), 0);
   endtask

   // vals/lvls: lane k uses entry k%4 (entry 0 in the low bits).
   task automatic run_sample(input logic [63:0] vals, input logic [15:0] lvls,
                             input logic [15:0] off, input logic [3:0] sh,
                             input bit stall, input bit poke, input int abort_chunk);
      int d0;
      int beats;
      int s;
      int guard;
      int diff;
      int lvl;
      bit rdy;
      logic [LANES-1:0] em;
      d0    = done_cnt;
      beats = 0;
      cfg_offset = off;
      cfg_shift  = sh;
      start      = 1'b1;
      step();
      start      = 1'b0;
      cfg_offset = ~off;
      cfg_shift  = sh ^ 4'hF;
      check("busy_after_start", 32'(busy), 1);
      for (int c = 0; c < NCH; c++) begin
         guard = 0;
         while (bus.in_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
         end
         check("in_ready", 32'(bus.in_ready), 1);
         for (int k = 0; k < LANES; k++) bus.in_values[k*VW +: VW] = vals[(k % 4)*16 +: 16];
         bus.in_valid = 1'b1;
         step();
         bus.in_valid  = 1'b0;
         bus.in_values = '0;
         check("out_valid_lat0", 32'(bus.out_valid), 0);
         check("in_ready_map", 32'(bus.in_ready), 0);
         step();
         s     = 0;
         guard = 0;
         for (int k = 0; k < LANES; k++) em[k] = (c * LANES + k) < FC;
         while (s < NSEG && guard < 200) begin
            guard++;
            check("out_valid", 32'(bus.out_valid), 1);
            check("out_chunk", 32'(bus.out_chunk), c);
            check("out_seg", 32'(bus.out_seg), s);
            check("mask_diff", 32'($countones(bus.out_lane_mask ^ em)), 0);
            if (c == NCH - 1) check("mask_ones", 32'($countones(bus.out_lane_mask)), 152);
            diff = 0;
            for (int k = 0; k < LANES; k++) begin
               lvl  = int'(lvls[(k % 4)*4 +: 4]);
               diff += seg_diff(k, lvl, em[k], s);
            end
            check("seg_bits", diff, 0);
            if (c == abort_chunk && s == 2) begin
               rst = 1'b1;
               step();
               check_idle("abort");
               rst = 1'b0;
               return;
            end
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = rdy;
            if (poke) begin
               start        = 1'($urandom_range(0, 1));
               bus.in_valid = 1'($urandom_range(0, 1));
            end
            step();
            bus.out_ready = 1'b0;
            start         = 1'b0;
            bus.in_valid  = 1'b0;
            if (rdy) begin
               s++;
               beats++;
            end
         end
      end
      check("beats", beats, 16);
      check("done_hi", 32'(done), 1);
      step();
      check("done_lo", 32'(done), 0);
      check("busy_end", 32'(busy), 0);
      check("done_pulses", done_cnt - d0, 1);
   endtask

   initial begin
      int d0;
      rst           = 1'b1;
      start         = 1'b0;
      cfg_offset    = '0;
      cfg_shift     = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_values = '0;
      step();
      step();
      check_idle("reset");
      rst = 1'b0;
      step();
      check("idle_busy", 32'(busy), 0);

      // Saturating run: 0x7FFF >> 11 = 15 on every lane.
      run_sample({4{16'h7FFF}}, {4{4'd15}}, 16'd0, 4'd11, 1'b0, 1'b0, -1);

      // offset 100, shift 0: {99,100,114,200} -> {0,0,14,15}; random stalls and pokes.
      run_sample({16'd200, 16'd114, 16'd100, 16'd99}, {4'd15, 4'd14, 4'd0, 4'd0},
                 16'd100, 4'd0, 1'b1, 1'b1, -1);

      // Negative offset and extremes: {-32768,-16,64,32767} - (-16) >> 3 -> {0,0,10,15}.
      run_sample({16'h7FFF, 16'h0040, 16'hFFF0, 16'h8000}, {4'd15, 4'd10, 4'd0, 4'd0},
                 16'hFFF0, 4'd3, 1'b1, 1'b0, -1);

      // Reset at chunk 1 seg 2, then a fresh sample must start at chunk 0 seg 0.
      d0 = done_cnt;
      run_sample({4{16'h7FFF}}, {4{4'd15}}, 16'd0, 4'd11, 1'b0, 1'b0, 1);
      for (int i = 0; i < 10; i++) step();
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_quiet", 32'(bus.out_valid), 0);
      run_sample({16'd200, 16'd114, 16'd100, 16'd99}, {4'd15, 4'd14, 4'd0, 4'd0},
                 16'd100, 4'd0, 1'b0, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
